axi_memory_master_burst: RTL and testbench

- AXI4 read-only master. Converts a single-cycle read command (address, total beat count, size, burst type) into one or more AR-channel bursts.
- Collects the R-channel data beats and presents each beat to the requester.
- Sits between front-end readers (e.g. the noise-estimation memory reader) and an AXI memory slave.

---
 rtl/axi_pkg.sv | 18 +
 rtl/axi_memory_master_burst.sv | 126 ++++++++++++
 tb/tb_axi_memory_master_burst.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants and the read-master FSM state encoding.
package axi_pkg;

   localparam logic [1:0] FIXED = 2'd0;
   localparam logic [1:0] INCR  = 2'd1;
   localparam logic [1:0] WRAP  = 2'd2;

   localparam logic [1:0] OKAY   = 2'd0;
   localparam logic [1:0] SLVERR = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/axi_memory_master_burst.sv
// AXI4 read-only master: splits one read command into MAX_BURST-sized AR bursts
// and forwards every R beat to the requester.
module axi_memory_master_burst
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int MAX_BURST  = 256
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start_read,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   input  logic [31:0]           read_len,
   input  logic [2:0]            read_size,
   input  logic [1:0]            read_burst,
   output logic [ID_WIDTH-1:0]   arid,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [7:0]            arlen,
   output logic [2:0]            arsize,
   output logic [1:0]            arburst,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [ID_WIDTH-1:0]   rid,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            rresp,
   input  logic                  rlast,
   input  logic                  rvalid,
   output logic                  rready,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  read_data_valid,
   output logic                  read_done,
   output logic                  read_error,
   output logic                  busy
);

   state_t                state, state_next;
   logic [31:0]           remaining;
   logic [31:0]           rem_next;
   logic [ADDR_WIDTH-1:0] burst_bytes;
   logic                  accept;
   logic                  beat;
   logic                  counted;
   logic                  unused_rid;

   function automatic logic [7:0] burst_len_m1(input logic [31:0] rem);
      if (rem >= 32'(MAX_BURST)) return 8'(MAX_BURST - 1);
      return 8'(rem - 32'd1);
   endfunction

   assign arid       = '0;
   assign unused_rid = ^rid;

   assign accept  = (state == IDLE) && start_read && (read_len != 32'd0);
   assign beat    = (state == DATA) && rvalid;
   // Beats arriving after the count is exhausted are swallowed, not counted.
   assign counted = beat && (remaining != 32'd0);
   assign rem_next = counted ? (remaining - 32'd1) : remaining;
   assign burst_bytes = ({{(ADDR_WIDTH-8){1'b0}}, arlen} + ADDR_WIDTH'(1)) << arsize;

   assign arvalid   = (state == ADDR);
   assign rready    = (state == DATA);
   assign read_done = (state == DONE);
   assign busy      = (state == ADDR) || (state == DATA);

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = ADDR;
         ADDR: if (arready) state_next = DATA;
         DATA: if (beat && rlast) state_next = (rem_next == 32'd0) ? DONE : ADDR;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         araddr          <= '0;
         arlen           <= '0;
         arsize          <= '0;
         arburst         <= '0;
         remaining       <= '0;
         read_data       <= '0;
         read_data_valid <= 1'b0;
         read_error      <= 1'b0;
      end else begin
         read_data_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  araddr     <= read_addr;
                  remaining  <= read_len;
                  arlen      <= burst_len_m1(read_len);
                  arsize     <= read_size;
                  arburst    <= read_burst;
                  read_error <= 1'b0;
               end
            end
            DATA: begin
               if (beat) begin
                  remaining <= rem_next;
                  if (counted) begin
                     read_data       <= rdata;
                     read_data_valid <= 1'b1;
                  end
                  if ((rresp != OKAY) || !counted) read_error <= 1'b1;
                  // Early or final rlast: set up the follow-on burst from what is left.
                  if (rlast && (rem_next != 32'd0)) begin
                     arlen <= burst_len_m1(rem_next);
                     if (arburst != FIXED) araddr <= araddr + burst_bytes;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_memory_master_burst.sv
// Scoreboard bench: reference model predicts AR bursts, beat data and error flag;
// a behavioural AXI slave serves reads from a synthetic memory.
module tb_axi_memory_master_burst;
   import axi_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 4;
   localparam int MB = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ar_t;

   logic          clk = 1'b0;
   logic          resetn;
   logic          start_read;
   logic [AW-1:0] read_addr;
   logic [31:0]   read_len;
   logic [2:0]    read_size;
   logic [1:0]    read_burst;
   logic [IW-1:0] arid;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          arvalid;
   logic          arready;
   logic [IW-1:0] rid;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rlast;
   logic          rvalid;
   logic          rready;
   logic [DW-1:0] read_data;
   logic          read_data_valid;
   logic          read_done;
   logic          read_error;
   logic          busy;

   axi_memory_master_burst #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .resetn(resetn), .start_read(start_read), .read_addr(read_addr),
      .read_len(read_len), .read_size(read_size), .read_burst(read_burst),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
      .rlast(rlast), .rvalid(rvalid), .rready(rready), .read_data(read_data),
      .read_data_valid(read_data_valid), .read_done(read_done),
      .read_error(read_error), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int data_cnt = 0;
   int last_rhs_cyc = -10;
   int last_rlast_cyc = -10;

   ar_t          exp_ar[$];
   logic [31:0]  exp_data[$];
   logic         exp_err[$];

   int err_beat = -1;
   int gap_mode = 0;
   int ar_stall = 0;
   int cmd_beat = 0;
   bit slave_flush = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9e37_79b1) ^ 32'h1234_abcd;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Behavioural slave
   initial begin
      ar_t  sl_q[$];
      ar_t  cap;
      int   sl_beat;
      int   stall_cnt;
      bit   ar_hs, r_hs, s_last, s_arvalid, tog, v;
      int   s_cyc;
      logic [31:0] a;
      sl_beat = 0; stall_cnt = 0; tog = 1'b0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
      forever begin
         @(negedge clk);
         ar_hs     = arvalid && arready;
         r_hs      = rvalid && rready;
         s_last    = rlast;
         s_arvalid = arvalid;
         s_cyc     = cyc;
         cap       = '{addr: araddr, len: arlen, size: arsize, burst: arburst};
         @(posedge clk);
         #1;
         if (slave_flush) begin
            sl_q.delete();
            sl_beat = 0; stall_cnt = 0;
            arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = '0;
            continue;
         end
         if (ar_hs) begin
            sl_q.push_back(cap);
            stall_cnt = 0;
         end else if (s_arvalid) begin
            stall_cnt++;
         end
         arready = (stall_cnt >= ar_stall);
         if (r_hs) begin
            last_rhs_cyc = s_cyc;
            cmd_beat++;
            sl_beat++;
            if (s_last) begin
               last_rlast_cyc = s_cyc;
               if (sl_q.size() > 0) void'(sl_q.pop_front());
               sl_beat = 0;
            end
         end
         tog = ~tog;
         if (rvalid && !r_hs) begin
            // hold the presented beat until it is taken
         end else if (sl_q.size() > 0) begin
            case (gap_mode)
               0:       v = 1'b1;
               1:       v = tog;
               default: v = ($urandom_range(2) != 0);
            endcase
            if (v) begin
               a = (sl_q[0].burst == FIXED) ? sl_q[0].addr
                                            : sl_q[0].addr + (32'(sl_beat) << sl_q[0].size);
               rdata  = mem_word(a);
               rlast  = (sl_beat == int'(sl_q[0].len));
               rresp  = (cmd_beat == err_beat) ? SLVERR : OKAY;
               rvalid = 1'b1;
            end else begin
               rvalid = 1'b0;
               rlast  = 1'b0;
            end
         end else begin
            rvalid = 1'b0;
            rlast  = 1'b0;
         end
      end
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!resetn) begin
         if (arvalid) begin
            if (exp_ar.size() == 0) fail("ar_unexpected");
            else begin
               chk("ar_chan", {arid, araddr, arlen, arsize, arburst},
                   {4'd0, exp_ar[0].addr, exp_ar[0].len, exp_ar[0].size, exp_ar[0].burst});
               if (arready) void'(exp_ar.pop_front());
            end
         end
         if (read_data_valid) begin
            data_cnt++;
            if (exp_data.size() == 0) fail("data_unexpected");
            else chk("read_data", read_data, exp_data.pop_front());
            chk("data_latency", cyc, last_rhs_cyc + 1);
         end
         if (read_done) begin
            done_cnt++;
            if (exp_err.size() == 0) fail("done_unexpected");
            else chk("read_error_at_done", read_error, exp_err.pop_front());
            chk("beats_left_at_done", exp_data.size(), 0);
            chk("ars_left_at_done", exp_ar.size(), 0);
            chk("busy_at_done", busy, 0);
            chk("done_latency", cyc, last_rlast_cyc + 1);
         end
      end
   end

   task automatic start_cmd(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input int ebeat, input int gap, input int stall);
      int rem, off, n;
      rem = len; off = 0;
      while (rem > 0) begin
         n = (rem > MB) ? MB : rem;
         exp_ar.push_back('{addr: (burst == FIXED) ? addr : addr + (32'(off) << size),
                            len: 8'(n - 1), size: size, burst: burst});
         rem -= n;
         off += n;
      end
      for (int k = 0; k < len; k++)
         exp_data.push_back(mem_word((burst == FIXED) ? addr : addr + (32'(k) << size)));
      if (len > 0) exp_err.push_back(ebeat >= 0 && ebeat < len);
      err_beat = ebeat; gap_mode = gap; ar_stall = stall; cmd_beat = 0;
      @(posedge clk); #1;
      start_read = 1'b1; read_addr = addr; read_len = 32'(len);
      read_size = size; read_burst = burst;
      @(posedge clk); #1;
      start_read = 1'b0; read_addr = $urandom; read_len = $urandom;
      @(negedge clk);
      chk("busy_after_start", busy, len != 0);
      chk("arvalid_after_start", arvalid, len != 0);
      if (len != 0) chk("error_cleared_on_start", read_error, 0);
   endtask

   task automatic wait_done(input int base);
      int t;
      t = 0;
      while (done_cnt == base && t < 3000) begin
         @(posedge clk);
         t++;
      end
      if (done_cnt == base) fail("timeout_waiting_read_done");
      @(posedge clk);
   endtask

   task automatic do_cmd(input logic [31:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input int ebeat, input int gap, input int stall);
      int base;
      base = done_cnt;
      start_cmd(addr, len, size, burst, ebeat, gap, stall);
      if (len == 0) begin
         repeat (10) begin
            @(negedge clk);
            chk("busy_zero_len", busy, 0);
         end
      end else begin
         wait_done(base);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_ar"}, {araddr, arlen, arsize, arburst, arvalid}, '0);
      chk({tag, "_r"}, {rready, read_data, read_data_valid, read_done, read_error, busy}, '0);
   endtask

   initial begin
      int base, t;
      logic [1:0] b;
      resetn = 1'b1; start_read = 1'b0; read_addr = '0; read_len = '0;
      read_size = '0; read_burst = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk); #3 resetn = 1'b0;

      do_cmd(32'h0000_0000, 4, 3'd2, INCR, -1, 0, 0);
      do_cmd(32'h0000_0100, 10, 3'd2, INCR, -1, 0, 0);
      do_cmd(32'h0000_0200, 6, 3'd2, INCR, -1, 0, 5);
      do_cmd(32'h0000_0300, 9, 3'd1, INCR, -1, 1, 0);
      do_cmd(32'h0000_0400, 8, 3'd2, INCR, 3, 0, 0);
      do_cmd(32'h0000_0500, 3, 3'd2, FIXED, -1, 2, 0);
      do_cmd(32'hFFFF_FFF8, 6, 3'd2, INCR, -1, 0, 1);
      do_cmd(32'h0000_0600, 1, 3'd0, INCR, 0, 0, 0);

      for (int i = 0; i < 20; i++) begin
         b = ($urandom_range(3) == 0) ? FIXED : INCR;
         do_cmd($urandom & 32'hFFFF_FFFC, int'($urandom_range(12, 1)), 3'($urandom_range(2)), b,
                ($urandom_range(3) == 0) ? int'($urandom_range(11)) : -1,
                int'($urandom_range(2)), int'($urandom_range(3)));
      end

      // Reset in the middle of the data phase
      base = data_cnt;
      start_cmd(32'h0000_0040, 8, 3'd2, INCR, -1, 0, 0);
      t = 0;
      while (data_cnt < base + 2 && t < 200) begin
         @(posedge clk);
         t++;
      end
      if (data_cnt < base + 2) fail("timeout_waiting_two_beats");
      @(posedge clk); #3;
      resetn = 1'b1; slave_flush = 1'b1;
      exp_ar.delete(); exp_data.delete(); exp_err.delete();
      @(negedge clk);
      check_outputs_zero("mid_reset");
      @(posedge clk); #3;
      resetn = 1'b0; slave_flush = 1'b0;

      do_cmd(32'h0000_0800, 4, 3'd2, INCR, -1, 0, 0);
      do_cmd(32'h0000_0900, 0, 3'd2, INCR, -1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
